carry_skip_adder_32bit: RTL and testbench
=========================================

CARRY_SKIP_ADDER_32BIT -- requirements
Module: carry_skip_adder_32bit

Interface
REQ-001 Parameter: BLOCK_SIZE, default 4, carry-skip block width in bits; the only supported value is 4, giving 8 blocks across 32 bits.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: A  input  32  addend A, unsigned.
REQ-005 Port: B  input  32  addend B, unsigned.
REQ-006 Port: cin  input  1  carry-in to bit 0.
REQ-007 Port: sum  output  32  registered sum bits [31:0].
REQ-008 Port: cout  output  1  registered carry-out of bit 31.
REQ-009 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst); no other clock or enable inputs.

Function
REQ-010 The datapath SHALL compute {cout_n, sum_n} = A + B + cin, 33-bit exact and unsigned, with no saturation or overflow flag.
REQ-011 The datapath SHALL split into 8 blocks of 4 bits: block k covers bits [4k+3:4k], and block 0 takes cin as its carry-in.
REQ-012 Inside each block: per-bit p = a^b, g = a&b, ripple carry c[i+1] = g | (p & c[i]), and sum bit = p ^ c[i].
REQ-013 Each block SHALL form its propagate P_k = AND of its four p bits.
REQ-014 Block carry-out SHALL be P_k ? block carry-in : ripple carry-out of bit 3, and SHALL feed the next block's carry-in.
REQ-015 The carry-out of block 7 SHALL be cout_n.
REQ-016 The skip mux SHALL be a distinct, visible structure per block; a single behavioural "+" for the whole 32 bits is not acceptable.
REQ-017 sum and cout SHALL register {cout_n, sum_n} on every rising clk edge while rst is low, giving a latency of exactly 1 cycle.
REQ-018 Inputs A, B and cin change freely every cycle; each registered result reflects the inputs sampled at that same edge, with no handshake.
REQ-019 Wrap-around: a result of 2^32 or more SHALL give cout=1 and sum = low 32 bits (for example FFFFFFFF+1 gives sum=0 and cout=1).
REQ-020 All-propagate case: when every P_k=1, cout SHALL equal cin and sum SHALL equal ~cin replicated across all 32 bits, i.e. sum = FFFFFFFF when cin=0 and sum = 00000000 when cin=1.
REQ-021 No latch shall be inferred; the combinational logic is fully defined for every input value, including X-free operation after reset.

Reset
REQ-022 When rst is asserted, sum SHALL go to 32'h00000000 and cout to 0 immediately, asynchronously, without waiting for a clock edge.
REQ-023 While rst is held, the outputs SHALL stay at zero regardless of clk, A, B and cin.
REQ-024 After rst deasserts, the first rising clk edge SHALL load a valid result.
REQ-025 Reset asserted mid-operation SHALL discard the pending result, with no partial update.

Verification
REQ-026 Corner cases: 0+0 with cin=0 -> sum=00000000, cout=0; 0+0 with cin=1 -> sum=00000001, cout=0; FFFFFFFF+00000001 with cin=0 -> sum=00000000, cout=1; 80000000+80000000 -> sum=00000000, cout=1.
REQ-027 Skip paths with B=0 and cin=1: A=0000000F -> sum=00000010; A=000000FF -> sum=00000100; A=00FFFFFF -> sum=01000000; A=FFFFFFFF -> sum=00000000, cout=1.
REQ-028 Full-propagate, no carry, cin=0: AAAAAAAA+55555555 -> sum=FFFFFFFF, cout=0; 11111111+EEEEEEEE -> sum=FFFFFFFF, cout=0; 0FFFFFFF+10000000 -> sum=1FFFFFFF, cout=0.
REQ-029 Mixed patterns: 12345678+87654321 with cin=0 -> sum=99999999, cin=1 -> sum=9999999A; DEADBEEF+01020304 -> sum=DFAFC1F3; 0F0F0F0F+01010101 -> sum=10101010, with cin=1 -> sum=10101011; cout=0 in all of these.
REQ-030 Timing and reset: apply inputs, then check the outputs 1 cycle later; assert rst asynchronously between edges -> outputs read 0 before the next edge; the first edge after release -> correct sum.
REQ-031 Random regression: at least 10,000 random A, B and cin vectors, each compared with the 33-bit reference A+B+cin one cycle later.

Source files
------------

// File: rtl/carry_skip_adder_32bit.sv
// 32-bit carry-skip adder: eight 4-bit ripple blocks with a per-block skip mux,
// result registered on every rising clock edge (1-cycle latency).
module carry_skip_adder_32bit #(
  parameter int BLOCK_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int NUM_BLOCKS = 32 / BLOCK_SIZE;

  logic [31:0]           w_p;
  logic [31:0]           w_g;
  logic [31:0]           w_sum;
  logic [NUM_BLOCKS-1:0] w_blk_p;
  logic [NUM_BLOCKS:0]   w_blk_c;

  assign w_p        = A ^ B;
  assign w_g        = A & B;
  assign w_blk_c[0] = cin;

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
    logic [BLOCK_SIZE:0] w_rc;

    assign w_rc[0] = w_blk_c[k];

    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_bit
      assign w_rc[i+1]                = w_g[k*BLOCK_SIZE+i] | (w_p[k*BLOCK_SIZE+i] & w_rc[i]);
      assign w_sum[k*BLOCK_SIZE+i]    = w_p[k*BLOCK_SIZE+i] ^ w_rc[i];
    end

    // When every bit propagates, the block carry-in bypasses the ripple chain.
    assign w_blk_p[k]   = &w_p[k*BLOCK_SIZE +: BLOCK_SIZE];
    assign w_blk_c[k+1] = w_blk_p[k] ? w_blk_c[k] : w_rc[BLOCK_SIZE];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= w_sum;
      cout <= w_blk_c[NUM_BLOCKS];
    end
  end

endmodule

// File: tb/tb_carry_skip_adder_32bit.sv
// Self-checking bench for carry_skip_adder_32bit: directed corner vectors,
// latency and asynchronous reset behaviour, then a random regression.
module tb_carry_skip_adder_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic [31:0] sum;
  logic        cout;

  int n_checks = 0;
  int n_fail   = 0;

  carry_skip_adder_32bit #(.BLOCK_SIZE(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {cout,sum}=%h expected %h", tag, got, exp);
    end
  endtask

  // Drive a vector between edges, then read the registered result just after the edge.
  task automatic apply_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic exp_cout, input logic [31:0] exp_sum);
    A   = a;
    B   = b;
    cin = ci;
    @(posedge clk);
    #1;
    check(tag, {cout, sum}, {exp_cout, exp_sum});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] rexp;

    rst = 1'b1;
    A   = 32'hFFFF_FFFF;
    B   = 32'hFFFF_FFFF;
    cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {cout, sum}, 33'h0);

    @(negedge clk);
    rst = 1'b0;
    apply_vec("first_after_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF);

    // Corner cases
    apply_vec("zero_cin0",  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    apply_vec("zero_cin1",  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001);
    apply_vec("wrap_ff_1",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000);
    apply_vec("msb_msb",    32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h0000_0000);

    // Carry rippling through successive skip blocks
    apply_vec("skip_0f",    32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010);
    apply_vec("skip_ff",    32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100);
    apply_vec("skip_ffffff",32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000);
    apply_vec("skip_all",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000);

    // Full propagate without carry
    apply_vec("prop_aa55",  32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF);
    apply_vec("prop_11ee",  32'h1111_1111, 32'hEEEE_EEEE, 1'b0, 1'b0, 32'hFFFF_FFFF);
    apply_vec("prop_0f_10", 32'h0FFF_FFFF, 32'h1000_0000, 1'b0, 1'b0, 32'h1FFF_FFFF);
    apply_vec("prop_aa55_c",32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0000);

    // Mixed patterns
    apply_vec("mix_1234_c0",32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999);
    apply_vec("mix_1234_c1",32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A);
    apply_vec("mix_dead",   32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0, 32'hDFAF_C1F3);
    apply_vec("mix_0f0f_c0",32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, 32'h1010_1010);
    apply_vec("mix_0f0f_c1",32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, 32'h1010_1011);

    // Latency: new inputs must not appear before the next edge
    A = 32'h0000_0001; B = 32'h0000_0001; cin = 1'b0;
    #2;
    check("latency_hold", {cout, sum}, {1'b0, 32'h1010_1011});
    @(posedge clk);
    #1;
    check("latency_load", {cout, sum}, {1'b0, 32'h0000_0002});

    // Asynchronous reset mid-operation, between edges
    A = 32'hFFFF_FFFF; B = 32'h0000_0001; cin = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", {cout, sum}, 33'h0);
    @(posedge clk);
    #1;
    check("reset_held_edge", {cout, sum}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_load", {cout, sum}, {1'b1, 32'h0000_0001});

    // Random regression against the 33-bit reference sum
    for (int i = 0; i < 10000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      apply_vec("random", ra, rb, rc, rexp[32], rexp[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
